// File: rtl/mem_pkg.sv
// Types and default geometry shared by the instruction-fetch line server and the instruction cache.
package mem_pkg;

    localparam int unsigned LINE_SIZE_DEF      = 64;
    localparam int unsigned ADDR_WIDTH_DEF     = 32;
    localparam int unsigned MEM_DATA_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } line_srv_state_t;

endpackage

// File: rtl/line_assembler.sv
// Line buffer: one memory word is written per beat; the whole line is always readable.
module line_assembler #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned BEATS  = 16,
    localparam int unsigned BEAT_W = $clog2(BEATS)
) (
    input  logic                      clk_i,
    input  logic                      i_we,
    input  logic [BEAT_W-1:0]         i_beat,
    input  logic [WORD_W-1:0]         i_word,
    output logic [WORD_W*BEATS-1:0]   o_line
);

    logic [WORD_W*BEATS-1:0] r_line;

    // Contents are only meaningful once a fill has completed, so no reset.
    always_ff @(posedge clk_i) begin
        if (i_we) begin
            r_line[i_beat*WORD_W +: WORD_W] <= i_word;
        end
    end

    assign o_line = r_line;

endmodule

// File: rtl/imem_line_server.sv
// Fetches one cache line from word-wide backing memory, one read in flight at a time.
// state | meaning: IDLE waiting for a line request | REQ word request on the bus
//       | WAIT waiting for read data | RESP full line presented to the consumer
module imem_line_server
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int unsigned LINE_SIZE      = LINE_SIZE_DEF,
    parameter int unsigned MEM_DATA_WIDTH = MEM_DATA_WIDTH_DEF
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        line_req_i,
    input  logic [ADDR_WIDTH-1:0]       line_addr_i,
    output logic                        line_req_ready_o,
    output logic                        line_resp_valid_o,
    input  logic                        line_resp_ready_i,
    output logic [ADDR_WIDTH-1:0]       line_resp_addr_o,
    output logic [LINE_SIZE*8-1:0]      line_resp_data_o,
    output logic                        line_resp_err_o,
    output logic                        mem_req_o,
    output logic [ADDR_WIDTH-1:0]       mem_addr_o,
    input  logic                        mem_gnt_i,
    input  logic                        mem_rvalid_i,
    input  logic [MEM_DATA_WIDTH-1:0]   mem_rdata_i,
    input  logic                        mem_err_i,
    input  logic                        abort_i
);

    localparam int unsigned BEATS      = LINE_SIZE * 8 / MEM_DATA_WIDTH;
    localparam int unsigned BEAT_W     = $clog2(BEATS);
    localparam int unsigned WORD_BYTES = MEM_DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(LINE_SIZE - 1);

    line_srv_state_t            r_state;
    line_srv_state_t            w_state_nxt;
    logic [BEAT_W-1:0]          r_beat;
    logic [ADDR_WIDTH-1:0]      r_base;
    logic                       r_err;
    logic                       r_drain;
    logic                       w_accept;
    logic                       w_last;
    logic                       w_beat_done;
    logic                       w_drain_set;
    logic [ADDR_WIDTH-1:0]      w_beat_off;
    logic [LINE_SIZE*8-1:0]     w_line;

    assign line_req_ready_o = (r_state == IDLE) && !r_drain;
    assign w_accept         = line_req_i && line_req_ready_o;
    assign w_last           = (r_beat == BEAT_W'(BEATS - 1));
    assign w_beat_done      = (r_state == WAIT) && mem_rvalid_i;
    assign w_beat_off       = ADDR_WIDTH'(r_beat) * ADDR_WIDTH'(WORD_BYTES);

    always_comb begin
        w_state_nxt = r_state;
        w_drain_set = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (abort_i) begin
                    w_state_nxt = IDLE;
                    // A read granted in this very cycle will still return data.
                    w_drain_set = mem_gnt_i;
                end else if (mem_gnt_i) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (abort_i) begin
                    w_state_nxt = IDLE;
                    w_drain_set = !mem_rvalid_i;
                end else if (mem_rvalid_i) begin
                    w_state_nxt = w_last ? RESP : REQ;
                end
            end
            RESP: begin
                if (abort_i || line_resp_ready_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_beat  <= '0;
            r_err   <= 1'b0;
            r_drain <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_beat <= '0;
                r_err  <= 1'b0;
            end else if (w_beat_done && !abort_i) begin
                r_err <= r_err | mem_err_i;
                if (!w_last) begin
                    r_beat <= r_beat + BEAT_W'(1);
                end
            end
            if (w_drain_set) begin
                r_drain <= 1'b1;
            end else if (mem_rvalid_i) begin
                r_drain <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_base <= line_addr_i & ALIGN_MASK;
        end
    end

    line_assembler #(
        .WORD_W (MEM_DATA_WIDTH),
        .BEATS  (BEATS)
    ) u_line_assembler (
        .clk_i  (clk_i),
        .i_we   (w_beat_done),
        .i_beat (r_beat),
        .i_word (mem_rdata_i),
        .o_line (w_line)
    );

    assign mem_req_o         = (r_state == REQ);
    assign mem_addr_o        = r_base + w_beat_off;
    assign line_resp_valid_o = (r_state == RESP);
    assign line_resp_addr_o  = r_base;
    assign line_resp_data_o  = w_line;
    assign line_resp_err_o   = r_err;

endmodule

// File: tb/tb_imem_line_server.sv
// Directed bench for imem_line_server with a single-outstanding memory model and a response scoreboard.
module tb_imem_line_server;

    logic           clk_i = 1'b0;
    logic           rst_ni = 1'b0;
    logic           line_req_i = 1'b0;
    logic [31:0]    line_addr_i = '0;
    logic           line_req_ready_o;
    logic           line_resp_valid_o;
    logic           line_resp_ready_i = 1'b0;
    logic [31:0]    line_resp_addr_o;
    logic [511:0]   line_resp_data_o;
    logic           line_resp_err_o;
    logic           mem_req_o;
    logic [31:0]    mem_addr_o;
    logic           mem_gnt_i = 1'b0;
    logic           mem_rvalid_i = 1'b0;
    logic [31:0]    mem_rdata_i = '0;
    logic           mem_err_i = 1'b0;
    logic           abort_i = 1'b0;

    always #5 clk_i = ~clk_i;

    imem_line_server dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .line_req_i        (line_req_i),
        .line_addr_i       (line_addr_i),
        .line_req_ready_o  (line_req_ready_o),
        .line_resp_valid_o (line_resp_valid_o),
        .line_resp_ready_i (line_resp_ready_i),
        .line_resp_addr_o  (line_resp_addr_o),
        .line_resp_data_o  (line_resp_data_o),
        .line_resp_err_o   (line_resp_err_o),
        .mem_req_o         (mem_req_o),
        .mem_addr_o        (mem_addr_o),
        .mem_gnt_i         (mem_gnt_i),
        .mem_rvalid_i      (mem_rvalid_i),
        .mem_rdata_i       (mem_rdata_i),
        .mem_err_i         (mem_err_i),
        .abort_i           (abort_i)
    );

    typedef struct {
        logic [31:0]  addr;
        logic [511:0] data;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] seed = '0;
    int          err_beat = 99;
    int          stall_beat = 99;
    int          stall_left = 0;
    int          rv_lat = 1;
    logic [31:0] exp_base = '0;
    int          n_gnt = 0;
    int          pend_cnt = 0;
    logic [31:0] pend_data = '0;
    logic        pend_err = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] mk_line(input logic [31:0] s);
        logic [511:0] l;
        l = '0;
        for (int k = 0; k < 16; k++) l[k*32 +: 32] = s + 32'(k);
        return l;
    endfunction

    // Memory: grant in the request cycle (unless stalled or busy), data rv_lat cycles later.
    initial begin
        forever begin
            @(negedge clk_i);
            if (prev_stall) begin
                chk("stall_req_held", mem_req_o, 1);
                chk("stall_addr_held", mem_addr_o, prev_addr);
            end
            mem_rvalid_i = 1'b0;
            mem_err_i    = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = pend_data;
                    mem_err_i    = pend_err;
                end
            end
            mem_gnt_i  = 1'b0;
            prev_stall = 1'b0;
            if (mem_req_o) begin
                if (pend_cnt == 0 && !(n_gnt == stall_beat && stall_left > 0)) begin
                    mem_gnt_i = 1'b1;
                    chk("mem_addr", mem_addr_o, exp_base + 32'(4 * n_gnt));
                    pend_cnt  = rv_lat;
                    pend_data = seed + 32'(mem_addr_o[5:2]);
                    pend_err  = (int'(mem_addr_o[5:2]) == err_beat);
                    n_gnt++;
                end else begin
                    if (n_gnt == stall_beat && stall_left > 0) stall_left--;
                    prev_stall = 1'b1;
                    prev_addr  = mem_addr_o;
                end
            end
        end
    end

    task automatic start_fill(input logic [31:0] addr, input logic [31:0] s, input int eb,
                              input int st_beat, input int st_len, input int lat, input bit want_resp);
        int t;
        seed       = s;
        err_beat   = eb;
        stall_beat = st_beat;
        stall_left = st_len;
        rv_lat     = lat;
        exp_base   = addr & 32'hFFFF_FFC0;
        n_gnt      = 0;
        if (want_resp) sb.push_back('{addr: exp_base, data: mk_line(s), err: (eb >= 0 && eb < 16)});
        @(negedge clk_i);
        line_req_i  = 1'b1;
        line_addr_i = addr;
        t = 0;
        while (!line_req_ready_o && t < 50) begin
            @(negedge clk_i);
            t++;
        end
        chk("req_ready", line_req_ready_o, 1);
        @(posedge clk_i);
        #1;
        line_req_i = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 1;
        while (!line_resp_valid_o && lat < 400) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        chk("resp_valid", line_resp_valid_o, 1);
    endtask

    task automatic check_resp(input int hold);
        exp_t e;
        chk("sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("resp_addr", line_resp_addr_o, e.addr);
            chk("resp_data", line_resp_data_o, e.data);
            chk("resp_err", line_resp_err_o, e.err);
            for (int i = 0; i < hold; i++) begin
                @(posedge clk_i);
                #1;
                chk("hold_valid", line_resp_valid_o, 1);
                chk("hold_data", line_resp_data_o, e.data);
                chk("hold_addr", line_resp_addr_o, e.addr);
                chk("hold_req_ready", line_req_ready_o, 0);
            end
        end
        line_resp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        line_resp_ready_i = 1'b0;
        chk("resp_done_valid", line_resp_valid_o, 0);
        chk("resp_done_ready", line_req_ready_o, 1);
    endtask

    initial begin
        int lat;
        int t;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_valid", line_resp_valid_o, 0);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_err", line_resp_err_o, 0);
        chk("rst_req_ready", line_req_ready_o, 1);
        rst_ni = 1'b1;

        // Basic fill with minimum latency
        start_fill(32'h0000_1234, 32'hA000_0000, 99, 99, 0, 1, 1'b1);
        wait_resp(lat);
        chk("latency", lat, 33);
        chk("basic_gnts", n_gnt, 16);
        check_resp(0);

        // Grant withheld for five cycles on beat 3
        start_fill(32'h0000_2040, 32'hB000_0000, 99, 3, 5, 1, 1'b1);
        wait_resp(lat);
        chk("stall_latency", lat, 38);
        check_resp(0);

        // Error on beat 7 only
        start_fill(32'h0000_3000, 32'hC000_0000, 7, 99, 0, 1, 1'b1);
        wait_resp(lat);
        chk("err_gnts", n_gnt, 16);
        check_resp(0);

        // Consumer back-pressure for ten cycles
        start_fill(32'h0000_4010, 32'hD000_0000, 99, 99, 0, 2, 1'b1);
        wait_resp(lat);
        check_resp(10);

        // Abort while waiting on beat 5, then refetch a different line
        start_fill(32'h0000_5000, 32'hE000_0000, 99, 99, 0, 3, 1'b0);
        t = 0;
        while (n_gnt < 6 && t < 300) begin
            @(posedge clk_i);
            #1;
            t++;
        end
        chk("abort_reach_beat5", n_gnt, 6);
        abort_i = 1'b1;
        @(posedge clk_i);
        #1;
        abort_i = 1'b0;
        chk("abort_valid", line_resp_valid_o, 0);
        chk("abort_mem_req", mem_req_o, 0);
        chk("abort_drain_ready", line_req_ready_o, 0);
        start_fill(32'h0000_6000, 32'h5500_0000, 99, 99, 0, 1, 1'b1);
        wait_resp(lat);
        check_resp(0);

        // Line at the top of the address space
        start_fill(32'hFFFF_FFC0, 32'h1234_0000, 99, 99, 0, 1, 1'b1);
        wait_resp(lat);
        chk("wrap_last_gnt", n_gnt, 16);
        check_resp(0);

        // Reset in the middle of a fill
        start_fill(32'h0000_7000, 32'h7700_0000, 99, 99, 0, 1, 1'b0);
        t = 0;
        while (n_gnt < 4 && t < 300) begin
            @(posedge clk_i);
            #1;
            t++;
        end
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        chk("midrst_mem_req", mem_req_o, 0);
        chk("midrst_valid", line_resp_valid_o, 0);
        chk("midrst_req_ready", line_req_ready_o, 1);
        repeat (5) @(posedge clk_i);
        #1;
        chk("midrst_no_resp", line_resp_valid_o, 0);

        start_fill(32'h0000_8008, 32'h8800_0000, 99, 99, 0, 1, 1'b1);
        wait_resp(lat);
        chk("recover_latency", lat, 33);
        check_resp(0);
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
